plane_hit_detector: RTL and testbench

//  Produces the per-frame planehit pulse consumed by the plane position mover, which recentres the plane on a hit.

---
 rtl/plane_game_pkg.sv | 30 +++
 rtl/aabb_overlap.sv | 49 ++++
 rtl/plane_hit_detector.sv | 196 +++++++++++++++++++
 tb/tb_plane_hit_detector.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/plane_game_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : plane_game_pkg
//  Purpose : Shared definitions for the plane game datapath: coordinate
//            width, screen geometry, default box sizes and the hit-detector
//            scan state encoding.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package plane_game_pkg;

  localparam int COORD_W  = 11;
  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;

  // Default collision box sizes in pixels.
  localparam int DEF_PLANE_W = 32;
  localparam int DEF_PLANE_H = 32;
  localparam int DEF_OBJ_W   = 32;
  localparam int DEF_OBJ_H   = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SNAP   = 2'd1,
    SCAN   = 2'd2,
    REPORT = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/aabb_overlap.sv
`default_nettype none
// ============================================================================
//  Module  : aabb_overlap
//  Purpose : Combinational axis-aligned bounding-box overlap test between the
//            plane box and one obstacle box. Sums are formed one bit wider
//            than the coordinates so a box near the right/bottom edge of the
//            coordinate range never wraps. Touching edges are not a hit.
//  Ports   : px, py   plane top-left corner
//            ox, oy   obstacle top-left corner
//            valid    obstacle slot occupied
//            hit      boxes overlap and slot is occupied
//  Rev     : 1.0  initial release
// ============================================================================
module aabb_overlap
  import plane_game_pkg::*;
#(
  parameter int PLANE_W = DEF_PLANE_W,
  parameter int PLANE_H = DEF_PLANE_H,
  parameter int OBJ_W   = DEF_OBJ_W,
  parameter int OBJ_H   = DEF_OBJ_H
) (
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] ox,
  input  logic [COORD_W-1:0] oy,
  input  logic               valid,
  output logic               hit
);

  localparam int EXT_W = COORD_W + 1;

  logic [EXT_W-1:0] px_e, py_e, ox_e, oy_e;
  logic [EXT_W-1:0] px_end, py_end, ox_end, oy_end;

  assign px_e   = {1'b0, px};
  assign py_e   = {1'b0, py};
  assign ox_e   = {1'b0, ox};
  assign oy_e   = {1'b0, oy};
  assign px_end = px_e + EXT_W'(PLANE_W);
  assign py_end = py_e + EXT_W'(PLANE_H);
  assign ox_end = ox_e + EXT_W'(OBJ_W);
  assign oy_end = oy_e + EXT_W'(OBJ_H);

  assign hit = valid
             & (px_e < ox_end) & (ox_e < px_end)
             & (py_e < oy_end) & (oy_e < py_end);

endmodule
`default_nettype wire

// File: rtl/plane_hit_detector.sv
`default_nettype none
// ============================================================================
//  Module  : plane_hit_detector
//  Purpose : Once per video frame, snapshots the plane position and scans the
//            obstacle table one slot per cycle through a 1-deep read pipeline,
//            testing each slot for box overlap. Overlapping slots are reported
//            for clearing; a hit on the frame pulses planehit, costs a life
//            and (optionally) starts an invulnerability cooldown.
//  Ports   : clk, rst             clock, synchronous active-high reset
//            frame_tick           frame strobe, starts a scan when idle
//            plane_x, plane_y     plane top-left position
//            obj_idx              obstacle table read address
//            obj_x, obj_y         obstacle position, 1 cycle after obj_idx
//            obj_valid            obstacle slot occupied, same timing
//            planehit             1-cycle pulse when a hit is accepted
//            clr_valid, clr_idx   request to clear an overlapping slot
//            lives                remaining lives
//            game_over            sticky once lives reach zero
//            busy                 scan in progress (SNAP/SCAN/REPORT)
//  Config  : HIT_COOLDOWN_EN  defined -> frames of invulnerability after a
//            hit; undefined -> every hit frame is accepted.
//  Rev     : 1.0  initial release
// ============================================================================
module plane_hit_detector
  import plane_game_pkg::*;
#(
  parameter int NUM_OBJ  = 8,
  parameter int PLANE_W  = DEF_PLANE_W,
  parameter int PLANE_H  = DEF_PLANE_H,
  parameter int OBJ_W    = DEF_OBJ_W,
  parameter int OBJ_H    = DEF_OBJ_H,
  parameter int LIVES    = 3,
  parameter int COOLDOWN = 60,
  localparam int IDX_W   = $clog2(NUM_OBJ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] plane_x,
  input  logic [COORD_W-1:0] plane_y,
  output logic [IDX_W-1:0]   obj_idx,
  input  logic [COORD_W-1:0] obj_x,
  input  logic [COORD_W-1:0] obj_y,
  input  logic               obj_valid,
  output logic               planehit,
  output logic               clr_valid,
  output logic [IDX_W-1:0]   clr_idx,
  output logic [2:0]         lives,
  output logic               game_over,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   obj_idx_q, obj_idx_d;
  logic [COORD_W-1:0] px_q, px_d;
  logic [COORD_W-1:0] py_q, py_d;
  logic               hit_any_q, hit_any_d;
  logic               clr_valid_q, clr_valid_d;
  logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
  logic [2:0]         lives_q, lives_d;
  logic               game_over_q, game_over_d;
  logic               cooldown_zero;

  // Slot whose data is on obj_x/obj_y this cycle: the address of last cycle.
  logic [IDX_W-1:0]   cmp_idx;
  logic               slot_hit;

  assign cmp_idx = obj_idx_q - IDX_W'(1);

`ifdef HIT_COOLDOWN_EN
  logic [7:0] cooldown_q, cooldown_d;
  assign cooldown_zero = (cooldown_q == 8'd0);
`else
  logic unused_cooldown;
  assign unused_cooldown = ^8'(COOLDOWN);
  assign cooldown_zero   = 1'b1;
`endif

  aabb_overlap #(
    .PLANE_W (PLANE_W),
    .PLANE_H (PLANE_H),
    .OBJ_W   (OBJ_W),
    .OBJ_H   (OBJ_H)
  ) u_aabb (
    .px    (px_q),
    .py    (py_q),
    .ox    (obj_x),
    .oy    (obj_y),
    .valid (obj_valid),
    .hit   (slot_hit)
  );

  always_comb begin
    state_d     = state_q;
    obj_idx_d   = obj_idx_q;
    px_d        = px_q;
    py_d        = py_q;
    hit_any_d   = hit_any_q;
    clr_valid_d = 1'b0;
    clr_idx_d   = clr_idx_q;
    lives_d     = lives_q;
    game_over_d = game_over_q;
    planehit    = 1'b0;
`ifdef HIT_COOLDOWN_EN
    cooldown_d  = cooldown_q;
`endif

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d   = SNAP;
          px_d      = plane_x;
          py_d      = plane_y;
          obj_idx_d = '0;
          hit_any_d = 1'b0;
`ifdef HIT_COOLDOWN_EN
          if (cooldown_q != 8'd0) cooldown_d = cooldown_q - 8'd1;
`endif
        end
      end

      // Slot 0 address is on the bus; its data arrives next cycle.
      SNAP: begin
        state_d   = SCAN;
        obj_idx_d = obj_idx_q + IDX_W'(1);
      end

      SCAN: begin
        obj_idx_d = obj_idx_q + IDX_W'(1);
        if (slot_hit) begin
          clr_valid_d = 1'b1;
          clr_idx_d   = cmp_idx;
          hit_any_d   = 1'b1;
        end
        // Address has wrapped to 0: this cycle compares the final slot.
        if (obj_idx_q == '0) begin
          state_d   = REPORT;
          obj_idx_d = '0;
        end
      end

      REPORT: begin
        state_d = IDLE;
        if (hit_any_q && cooldown_zero && !game_over_q) begin
          planehit = 1'b1;
          lives_d  = lives_q - 3'd1;
          if (lives_q == 3'd1) game_over_d = 1'b1;
`ifdef HIT_COOLDOWN_EN
          cooldown_d = 8'(COOLDOWN);
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      obj_idx_q   <= '0;
      px_q        <= '0;
      py_q        <= '0;
      hit_any_q   <= 1'b0;
      clr_valid_q <= 1'b0;
      clr_idx_q   <= '0;
      lives_q     <= 3'(LIVES);
      game_over_q <= 1'b0;
`ifdef HIT_COOLDOWN_EN
      cooldown_q  <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      obj_idx_q   <= obj_idx_d;
      px_q        <= px_d;
      py_q        <= py_d;
      hit_any_q   <= hit_any_d;
      clr_valid_q <= clr_valid_d;
      clr_idx_q   <= clr_idx_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
`ifdef HIT_COOLDOWN_EN
      cooldown_q  <= cooldown_d;
`endif
    end
  end

  assign obj_idx   = obj_idx_q;
  assign clr_valid = clr_valid_q;
  assign clr_idx   = clr_idx_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_plane_hit_detector.sv
`default_nettype none
// ============================================================================
//  Module  : tb_plane_hit_detector
//  Purpose : Self-checking bench for plane_hit_detector. An obstacle table
//            with a 1-cycle registered read port feeds the DUT; a frame-level
//            reference model predicts overlapping slots, hit acceptance,
//            lives, cooldown and game-over from the box rules directly.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_plane_hit_detector;

  localparam int N   = 8;
  localparam int LIV = 3;
  localparam int CD  = 60;
  localparam int BW  = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic [10:0] plane_x = '0, plane_y = '0;
  logic [2:0]  obj_idx;
  logic [10:0] obj_x, obj_y;
  logic        obj_valid;
  logic        planehit, clr_valid, game_over, busy;
  logic [2:0]  clr_idx, lives;

  plane_hit_detector #(.NUM_OBJ(N), .LIVES(LIV), .COOLDOWN(CD)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .plane_x    (plane_x),
    .plane_y    (plane_y),
    .obj_idx    (obj_idx),
    .obj_x      (obj_x),
    .obj_y      (obj_y),
    .obj_valid  (obj_valid),
    .planehit   (planehit),
    .clr_valid  (clr_valid),
    .clr_idx    (clr_idx),
    .lives      (lives),
    .game_over  (game_over),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Obstacle table with a registered read port.
  int tx [N];
  int ty [N];
  bit tv [N];

  always @(posedge clk) begin
    obj_x     <= 11'(tx[obj_idx]);
    obj_y     <= 11'(ty[obj_idx]);
    obj_valid <= tv[obj_idx];
  end

  // Reference model state.
  int m_lives;
  int m_cd;
  bit m_go;
  int ph_total;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampc(input int v);
    return (v < 0) ? 0 : ((v > 2047) ? 2047 : v);
  endfunction

  function automatic bit boxes_touch(input int px, input int py, input int ox, input int oy);
    return (px < ox + BW) && (ox < px + BW) && (py < oy + BW) && (oy < py + BW);
  endfunction

  task automatic clear_tbl();
    for (int i = 0; i < N; i++) begin
      tx[i] = 0; ty[i] = 0; tv[i] = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_lives = LIV; m_cd = 0; m_go = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // One full frame: start a scan, watch every cycle until idle, compare.
  task automatic run_frame(input int px, input int py, input bit extra_tick);
    int exp_mask, exp_cnt, got_mask, got_cnt, ph_cnt, ph_cyc, busy_cnt;
    bit hit, exp_ph;
    exp_mask = 0; exp_cnt = 0;
    for (int i = 0; i < N; i++)
      if (tv[i] && boxes_touch(px, py, tx[i], ty[i])) begin
        exp_mask |= (1 << i); exp_cnt++;
      end
    hit = (exp_mask != 0);
`ifdef HIT_COOLDOWN_EN
    if (m_cd > 0) m_cd--;
`endif
    exp_ph = hit && (m_cd == 0) && !m_go;
    if (exp_ph) begin
      m_lives--;
`ifdef HIT_COOLDOWN_EN
      m_cd = CD;
`endif
      if (m_lives == 0) m_go = 1'b1;
    end

    plane_x = 11'(px); plane_y = 11'(py);
    frame_tick = 1'b1;
    got_mask = 0; got_cnt = 0; ph_cnt = 0; ph_cyc = -1; busy_cnt = 0;
    for (int k = 1; k <= N + 3; k++) begin
      @(posedge clk); #1;
      if (k == 1) frame_tick = 1'b0;
      if (extra_tick && k == 3) frame_tick = 1'b1;
      if (extra_tick && k == 4) frame_tick = 1'b0;
      if (planehit) begin ph_cnt++; ph_cyc = k; end
      if (clr_valid) begin got_mask |= (1 << clr_idx); got_cnt++; end
      if (busy) busy_cnt++;
    end
    ph_total += ph_cnt;
    check("planehit_count", ph_cnt, exp_ph ? 1 : 0);
    if (exp_ph) check("planehit_latency", ph_cyc, N + 2);
    check("clr_mask", got_mask, exp_mask);
    check("clr_count", got_cnt, exp_cnt);
    check("lives", 32'(lives), m_lives);
    check("game_over", 32'(game_over), 32'(m_go));
    check("busy_cycles", busy_cnt, N + 2);
  endtask

  initial begin
    int ph_cnt;
    int px, py;
    clear_tbl();
    model_reset();
    ph_total = 0;

    // Reset and idle.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_lives", 32'(lives), LIV);
    check("rst_game_over", 32'(game_over), 0);
    check("rst_planehit", 32'(planehit), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_obj_idx", 32'(obj_idx), 0);
    check("rst_clr_valid", 32'(clr_valid), 0);

    // Single overlapping slot 3.
    tx[3] = 500; ty[3] = 640; tv[3] = 1'b1;
    run_frame(496, 650, 1'b0);
    check("first_hit_lives", 32'(lives), LIV - 1);

    // Touching right edge: not a hit.
    reset_dut();
    clear_tbl();
    tx[5] = 528; ty[5] = 650; tv[5] = 1'b1;
    ph_total = 0;
    run_frame(496, 650, 1'b0);
    check("touch_no_hit", ph_total, 0);

    // Overlap on three consecutive frames.
    reset_dut();
    clear_tbl();
    tx[3] = 500; ty[3] = 640; tv[3] = 1'b1;
    ph_total = 0;
    for (int f = 0; f < 3; f++) run_frame(496, 650, 1'b0);
`ifdef HIT_COOLDOWN_EN
    check("three_frames_hits", ph_total, 1);
    check("three_frames_go", 32'(game_over), 0);
`else
    check("three_frames_hits", ph_total, 3);
    check("three_frames_go", 32'(game_over), 1);
`endif

    // Extra frame_tick during a scan is ignored.
    reset_dut();
    run_frame(496, 650, 1'b1);
    run_frame(496, 650, 1'b0);

    // Reset in the middle of a scan with an overlap present.
    reset_dut();
    frame_tick = 1'b1;
    ph_cnt = 0;
    for (int k = 1; k <= N + 3; k++) begin
      @(posedge clk); #1;
      if (k == 1) frame_tick = 1'b0;
      if (k == 6) begin
        check("midrst_lives", 32'(lives), LIV);
        check("midrst_busy", 32'(busy), 0);
        rst = 1'b0;
      end
      if (k == 5) rst = 1'b1;
      if (planehit) ph_cnt++;
    end
    check("midrst_no_hit", ph_cnt, 0);
    model_reset();

    // Randomized frames around the plane, several game lifetimes.
    for (int e = 0; e < 4; e++) begin
      reset_dut();
      for (int f = 0; f < 12; f++) begin
        px = $urandom_range(0, 2047);
        py = $urandom_range(0, 2047);
        for (int i = 0; i < N; i++) begin
          tv[i] = 1'($urandom_range(0, 1));
          tx[i] = clampc(px + $urandom_range(0, 100) - 50);
          ty[i] = clampc(py + $urandom_range(0, 100) - 50);
        end
        run_frame(px, py, (f % 4) == 3);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit.
  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
